// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM state codes, parity_type bit positions, parity helper.
package uart_pkg;

    localparam int unsigned DATA_W      = 8;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned STATE_W     = 3;
    localparam int unsigned PAR_EN_BIT  = 1;
    localparam int unsigned PAR_ODD_BIT = 0;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Parity bit that makes the total count of ones even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(input logic [DATA_W-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART frame serializer: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
// One bit per clock; txd/tx_rdy are registered from the next state so they track present_state.
module uart_tx
    import uart_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              tx_en,
    input  logic [1:0]        parity_type,
    input  logic              nstop,
    output logic              txd,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              tx_rdy
);

    state_t              present_state;
    state_t              next_state;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_next;
    logic [DATA_W-1:0]   data_q;
    logic [DATA_W-1:0]   data_d;
    logic [1:0]          par_q;
    logic [1:0]          par_d;
    logic                nstop_q;
    logic                nstop_d;
    logic                accept;
    logic                txd_next;
    logic                rdy_next;

    // Next-state, counter and shadow-register update.
    always_comb begin
        next_state = present_state;
        cnt_next   = cnt;
        accept     = 1'b0;
        case (present_state)
            IDLE: begin
                if (tx_en && data_valid) begin
                    next_state = START;
                    accept     = 1'b1;
                end
            end
            START: begin
                next_state = DATA;
                cnt_next   = '0;
            end
            DATA: begin
                cnt_next = CNT_W'(cnt + CNT_W'(1));
                if (cnt == CNT_W'(DATA_W - 1)) begin
                    next_state = par_q[PAR_EN_BIT] ? PARITY : STOP1;
                end
            end
            PARITY:  next_state = STOP1;
            STOP1:   next_state = nstop_q ? STOP2 : IDLE;
            STOP2:   next_state = IDLE;
            default: next_state = IDLE;
        endcase

        data_d  = accept ? data_in     : data_q;
        par_d   = accept ? parity_type : par_q;
        nstop_d = accept ? nstop       : nstop_q;
    end

    // Moore output decode of the state being entered.
    always_comb begin
        txd_next = 1'b1;
        rdy_next = 1'b0;
        case (next_state)
            IDLE:    rdy_next = 1'b1;
            START:   txd_next = 1'b0;
            DATA:    txd_next = data_d[cnt_next];
            PARITY:  txd_next = parity_bit(data_d, par_d[PAR_ODD_BIT]);
            default: txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            present_state <= IDLE;
            cnt           <= '0;
            data_q        <= '0;
            par_q         <= '0;
            nstop_q       <= 1'b0;
            txd           <= 1'b1;
            tx_rdy        <= 1'b1;
        end else begin
            present_state <= next_state;
            cnt           <= cnt_next;
            data_q        <= data_d;
            par_q         <= par_d;
            nstop_q       <= nstop_d;
            txd           <= txd_next;
            tx_rdy        <= rdy_next;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized bench for uart_tx against a frame-queue reference model.
module tb_uart_tx;
    import uart_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       tx_en;
    logic [1:0] parity_type;
    logic       nstop;
    logic       txd;
    logic [7:0] data_in;
    logic       data_valid;
    logic       tx_rdy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic   bit_val;
        state_t st;
    } slot_t;

    slot_t q[$];
    slot_t cur;

    uart_tx dut (
        .clock       (clock),
        .reset       (reset),
        .tx_en       (tx_en),
        .parity_type (parity_type),
        .nstop       (nstop),
        .txd         (txd),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .tx_rdy      (tx_rdy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Whole frame as the ordered list of (line level, state) slots it occupies.
    task automatic build_frame(input logic [7:0] d, input logic [1:0] pt, input logic ns);
        int ones;
        q.delete();
        q.push_back('{1'b0, START});
        for (int i = 0; i < 8; i++) q.push_back('{d[i], DATA});
        if (pt[1]) begin
            ones = $countones(d) + int'(pt[0]);
            q.push_back('{logic'(ones % 2), PARITY});
        end
        q.push_back('{1'b1, STOP1});
        if (ns) q.push_back('{1'b1, STOP2});
    endtask

    // Apply one cycle of inputs, advance the model, then compare all outputs.
    task automatic step(input logic rst, input logic en, input logic dv,
                        input logic [7:0] d, input logic [1:0] pt, input logic ns);
        reset       = rst;
        tx_en       = en;
        data_valid  = dv;
        data_in     = d;
        parity_type = pt;
        nstop       = ns;
        @(posedge clock);
        if (rst) begin
            q.delete();
            cur = '{1'b1, IDLE};
        end else if (cur.st == IDLE) begin
            if (en && dv) begin
                build_frame(d, pt, ns);
                cur = q.pop_front();
            end
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = '{1'b1, IDLE};
        end
        #1;
        check("txd", 8'(txd), 8'(cur.bit_val));
        check("tx_rdy", 8'(tx_rdy), 8'(cur.st == IDLE));
        check("state", 8'(dut.present_state), 8'(cur.st));
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    endtask

    initial begin
        logic [9:0] a5_line;
        logic [9:0] a5_seen;
        cur = '{1'b1, IDLE};

        step(1'b1, 1'b0, 1'b0, 8'h00, 2'b00, 1'b0);
        check("reset_txd", 8'(txd), 8'h01);
        check("reset_rdy", 8'(tx_rdy), 8'h01);
        idle_cycles(2);

        // 0xA5, no parity, one stop bit: line pattern in transmit order.
        a5_line = 10'b1101001010;
        step(1'b0, 1'b1, 1'b1, 8'hA5, 2'b00, 1'b0);
        a5_seen[0] = txd;
        for (int i = 1; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
            a5_seen[i] = txd;
        end
        check("a5_line", 8'(a5_seen[7:0]), 8'(a5_line[7:0]));
        check("a5_line_hi", 8'(a5_seen[9:8]), 8'(a5_line[9:8]));
        idle_cycles(1);
        check("a5_idle_rdy", 8'(tx_rdy), 8'h01);

        // 0x07 even parity, two stops; parity bit checked against constant.
        step(1'b0, 1'b1, 1'b1, 8'h07, 2'b10, 1'b1);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        check("even_par_bit", 8'(txd), 8'h01);
        idle_cycles(3);
        check("even_back_idle", 8'(dut.present_state), 8'(IDLE));

        // 0x07 odd parity with tx_en toggling and junk inputs mid-frame.
        step(1'b0, 1'b1, 1'b1, 8'h07, 2'b11, 1'b0);
        for (int i = 0; i < 9; i++)
            step(1'b0, 1'($urandom_range(0, 1)), 1'b1, 8'($urandom), 2'($urandom), 1'($urandom));
        check("odd_par_bit", 8'(txd), 8'h00);
        idle_cycles(2);

        // data_valid without tx_en is dropped.
        step(1'b0, 1'b0, 1'b1, 8'h3C, 2'b00, 1'b0);
        check("no_en_rdy", 8'(tx_rdy), 8'h01);
        idle_cycles(1);

        // Reset in the middle of the data bits.
        step(1'b0, 1'b1, 1'b1, 8'h00, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 2'b00, 1'b0);
        check("mid_reset_txd", 8'(txd), 8'h01);

        // Random regression.
        for (int it = 0; it < 1000; it++) begin
            for (int c = 0; c < 4; c++) begin
                step(1'($urandom_range(0, 199) == 0),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 1)),
                     8'($urandom), 2'($urandom), 1'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
